// File: rtl/prec_scalable_mac_seq_pkg.sv
// mac_pkg: precision modes, FSM states and weight-slice geometry shared by prec_scalable_mac_seq.
package mac_pkg;
  typedef enum logic [1:0] {PREC_8 = 2'b00, PREC_4X2 = 2'b01, PREC_2X4 = 2'b10, PREC_RSV = 2'b11} prec_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;
  localparam int NUM_SLICE = 4;
  localparam int SLICE_W = 2;
endpackage

// File: rtl/prec_scalable_mac_seq_if.sv
// mac_if: run control, input stream and result handshake bundle of prec_scalable_mac_seq.
interface mac_if #(
  parameter int ACT_W = 8,
  parameter int LANE_W = 14,
  parameter int LEN_W = 8
);
  logic start;
  logic [1:0] cfg_prec;
  logic [LEN_W-1:0] cfg_len;
  logic in_valid, in_ready;
  logic [ACT_W-1:0] act;
  logic [7:0] wgt;
  logic out_valid, out_ready;
  logic [4*LANE_W-1:0] result;
  logic cfg_err, sat_flag;
  modport master (
    output start, cfg_prec, cfg_len, in_valid, act, wgt, out_ready,
    input in_ready, out_valid, result, cfg_err, sat_flag
  );
  modport slave (
    input start, cfg_prec, cfg_len, in_valid, act, wgt, out_ready,
    output in_ready, out_valid, result, cfg_err, sat_flag
  );
endinterface

// File: rtl/prec_scalable_mac_seq_mult_slice.sv
// mult_slice: signed activation times one 2-bit weight slice, slice signedness selected by sgn.
module mult_slice
  import mac_pkg::*;
#(
  parameter int ACT_W = 8
) (
  input logic [ACT_W-1:0] act,
  input logic [SLICE_W-1:0] slice,
  input logic sgn,
  output logic [ACT_W+1:0] prod
);
  logic signed [ACT_W+1:0] a, b;
  assign a = {{2{act[ACT_W-1]}}, act};
  assign b = {{ACT_W{sgn & slice[SLICE_W-1]}}, slice};
  assign prod = a * b;
endmodule

// File: rtl/prec_scalable_mac_seq.sv
// prec_scalable_mac_seq: precision-scalable MAC fusing 1/2/4 signed products into a lane-split accumulator.
// Define MAC_SAT_EN to saturate each active partition instead of wrapping.
module prec_scalable_mac_seq
  import mac_pkg::*;
#(
  parameter int ACT_W = 8,
  parameter int LANE_W = 14,
  parameter int LEN_W = 8
) (
  input logic clk,
  input logic rst,
  mac_if.slave m
);
  localparam int ACC_W = NUM_SLICE * LANE_W;
  state_e st;
  prec_e prec;
  logic [LEN_W-1:0] len, cnt;
  logic [NUM_SLICE-1:0][LANE_W-1:0] acc, prod_r, fused, sum, s;
  logic signed [ACT_W+1:0] p [NUM_SLICE];
  logic signed [ACC_W-1:0] f8;
  logic signed [2*LANE_W-1:0] fh, fl;
  logic [NUM_SLICE-1:0] sgn, cut;
  logic [NUM_SLICE:0] c;
  logic v1, hs, ovf_any;
  assign hs = m.in_valid & m.in_ready;
  assign sgn = {1'b1, prec == PREC_2X4, prec != PREC_8, prec == PREC_2X4};
  assign cut = {prec == PREC_2X4, prec != PREC_8, prec == PREC_2X4, 1'b1};
  assign m.result = acc;
  for (genvar i = 0; i < NUM_SLICE; i++) begin : g_sl
    mult_slice #(.ACT_W(ACT_W)) u_ms (
      .act(m.act),
      .slice(m.wgt[SLICE_W*i +: SLICE_W]),
      .sgn(sgn[i]),
      .prod(p[i])
    );
  end
  always_comb begin
    f8 = (ACC_W'(p[3]) << 6) + (ACC_W'(p[2]) << 4) + (ACC_W'(p[1]) << 2) + ACC_W'(p[0]);
    fh = ((2*LANE_W)'(p[3]) << 2) + (2*LANE_W)'(p[2]);
    fl = ((2*LANE_W)'(p[1]) << 2) + (2*LANE_W)'(p[0]);
    fused = prec == PREC_8 ? f8 : prec == PREC_4X2 ? {fh, fl} :
            {LANE_W'(p[3]), LANE_W'(p[2]), LANE_W'(p[1]), LANE_W'(p[0])};
  end
  // lane adders chained through c; cut[k] breaks the carry into lane k at partition boundaries
  always_comb begin
    c = '0;
    s = '0;
    for (int k = 0; k < NUM_SLICE; k++)
      {c[k+1], s[k]} = {1'b0, acc[k]} + {1'b0, prod_r[k]} + (LANE_W+1)'(c[k] & ~cut[k]);
  end
`ifdef MAC_SAT_EN
  logic [NUM_SLICE-1:0] top, ovf;
  logic [1:0] ow;
  logic sg;
  assign top = {1'b1, cut[NUM_SLICE-1:1]};
  always_comb begin
    ovf = '0;
    sum = s;
    ow = '0;
    sg = 1'b0;
    for (int k = 0; k < NUM_SLICE; k++)
      ovf[k] = top[k] & (acc[k][LANE_W-1] == prod_r[k][LANE_W-1]) & (s[k][LANE_W-1] != acc[k][LANE_W-1]);
    for (int k = 0; k < NUM_SLICE; k++) begin
      ow = prec == PREC_8 ? 2'd3 : prec == PREC_4X2 ? {k[1], 1'b1} : k[1:0];
      sg = acc[ow][LANE_W-1];
      if (ovf[ow]) sum[k] = k[1:0] == ow ? {sg, {(LANE_W-1){~sg}}} : {LANE_W{~sg}};
    end
  end
  assign ovf_any = |ovf;
`else
  assign sum = s;
  assign ovf_any = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      prec <= PREC_8;
      len <= '0;
      cnt <= '0;
      acc <= '0;
      prod_r <= '0;
      v1 <= 1'b0;
      m.in_ready <= 1'b0;
      m.out_valid <= 1'b0;
      m.cfg_err <= 1'b0;
      m.sat_flag <= 1'b0;
    end else begin
      v1 <= hs;
      if (hs) prod_r <= fused;
      if (v1) begin
        acc <= sum;
        m.sat_flag <= m.sat_flag | ovf_any;
      end
      case (st)
        IDLE: if (m.start) begin
          if (m.cfg_len == '0 || m.cfg_prec == PREC_RSV) m.cfg_err <= 1'b1;
          m.sat_flag <= 1'b0;
          if (m.cfg_len != '0) begin
            st <= RUN;
            prec <= m.cfg_prec == PREC_RSV ? PREC_8 : prec_e'(m.cfg_prec);
            len <= m.cfg_len;
            cnt <= '0;
            acc <= '0;
            m.in_ready <= 1'b1;
          end
        end
        RUN: if (hs) begin
          cnt <= cnt + 1'b1;
          if (cnt == len - 1'b1) begin
            st <= DRAIN;
            m.in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          st <= OUT;
          m.out_valid <= 1'b1;
        end
        OUT: if (m.out_ready) begin
          st <= IDLE;
          m.out_valid <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_prec_scalable_mac_seq.sv
// tb_prec_scalable_mac_seq: directed runs of prec_scalable_mac_seq checked against a per-partition arithmetic model.
module tb_prec_scalable_mac_seq;
  localparam int ACT_W = 8, LANE_W = 14, LEN_W = 8, ACC_W = 4*LANE_W;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mac_if #(.ACT_W(ACT_W), .LANE_W(LANE_W), .LEN_W(LEN_W)) bus ();
  prec_scalable_mac_seq #(.ACT_W(ACT_W), .LANE_W(LANE_W), .LEN_W(LEN_W)) dut (
    .clk(clk),
    .rst(rst),
    .m(bus)
  );
  int total = 0, bad = 0, cyc = 0, last_hs = -100;
  logic [ACC_W-1:0] exp_res = '0, got, lit;
  logic exp_sat = 1'b0, prev_ov = 1'b0, msat;
  int st_act [256], st_wgt [256];

  task automatic chk(input string nm, input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic chk1(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask
  task automatic chki(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  function automatic longint sl(input int w, input int k, input bit sg);
    longint v = longint'((w >> (2*k)) & 3);
    return (sg && v > 1) ? v - 4 : v;
  endfunction

  // each partition is an independent signed accumulator of width 56/28/14
  task automatic model(input int prec, input int len, output logic [ACC_W-1:0] r, output logic sat);
    int md = (prec == 3) ? 0 : prec;
    int np = md == 0 ? 1 : md == 1 ? 2 : 4;
    int pw = ACC_W / np;
    longint lim = longint'(1) << (pw - 1);
    longint s [4];
    longint p [4];
    longint v;
    for (int j = 0; j < 4; j++) s[j] = 0;
    sat = 1'b0;
    r = '0;
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 4; k++)
        p[k] = longint'(st_act[i]) * sl(st_wgt[i], k, md == 2 || k == 3 || (md == 1 && k == 1));
      for (int j = 0; j < np; j++) begin
        v = md == 0 ? p[3]*64 + p[2]*16 + p[1]*4 + p[0] : md == 1 ? p[2*j+1]*4 + p[2*j] : p[j];
        s[j] += v;
`ifdef MAC_SAT_EN
        if (s[j] >= lim) begin
          s[j] = lim - 1;
          sat = 1'b1;
        end else if (s[j] < -lim) begin
          s[j] = -lim;
          sat = 1'b1;
        end
`else
        s[j] = ((s[j] + lim) & (2*lim - 1)) - lim;
`endif
      end
    end
    for (int j = 0; j < np; j++) r |= ACC_W'(s[j] & (2*lim - 1)) << (j*pw);
  endtask

  always @(posedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) last_hs = cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk)
    if (!rst) begin
      if (bus.out_valid) begin
        if (!prev_ov) chki("latency", cyc - last_hs, 2);
        chk("result", bus.result, exp_res);
        chk1("sat_flag", bus.sat_flag, exp_sat);
        chk1("in_ready_out", bus.in_ready, 1'b0);
      end
      prev_ov = bus.out_valid;
    end

  task automatic run(input int prec, input int len, input int gap, input int hold);
    model(prec, len, exp_res, exp_sat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.cfg_prec = prec[1:0];
    bus.cfg_len = len[LEN_W-1:0];
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (gap != 0 && i == 1) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.act = st_act[i][ACT_W-1:0];
      bus.wgt = st_wgt[i][7:0];
      for (int n = 0; n < 10 && !bus.in_ready; n++) @(negedge clk);
      chk1("in_ready_wait", bus.in_ready, 1'b1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = (hold == 0);
    for (int n = 0; n < 10 && !bus.out_valid; n++) @(negedge clk);
    chk1("out_valid_wait", bus.out_valid, 1'b1);
    got = bus.result;
    if (hold != 0) begin
      for (int h = 0; h < hold; h++) begin
        bus.start = 1'b1;
        bus.cfg_len = 1;
        @(negedge clk);
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk("hold_result", bus.result, got);
      end
      bus.start = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk1("accept", bus.out_valid, 1'b0);
    @(negedge clk);
    chk1("idle_ready", bus.in_ready, 1'b0);
    chk1("idle_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.cfg_prec = 2'b00;
    bus.cfg_len = '0;
    bus.in_valid = 1'b0;
    bus.act = '0;
    bus.wgt = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, '0);
    chk1("rst_cfg_err", bus.cfg_err, 1'b0);
    chk1("rst_sat_flag", bus.sat_flag, 1'b0);

    st_act[0] = -3; st_wgt[0] = 8'h05;
    run(0, 1, 0, 0);
    chk("t1_model", exp_res, 56'hFFFFFFFFFFFFF1);
    chk("t1_result", got, 56'hFFFFFFFFFFFFF1);

    for (int i = 0; i < 2; i++) begin st_act[i] = 10; st_wgt[i] = 8'h78; end
    run(2, 2, 1, 0);
    lit = {14'd20, 14'h3FEC, 14'h3FD8, 14'd0};
    chk("t2_model", exp_res, lit);
    chk("t2_result", got, lit);

    for (int i = 0; i < 3; i++) begin st_act[i] = -128; st_wgt[i] = 8'h7F; end
    run(1, 3, 0, 5);
    lit = {28'hFFFF580, 28'h0000180};
    chk("t3_model", exp_res, lit);
    chk("t3_result", got, lit);

    @(negedge clk);
    bus.start = 1'b1; bus.cfg_prec = 2'b00; bus.cfg_len = 8;
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1; bus.act = 8'd100; bus.wgt = 8'hFF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_result", bus.result, '0);
    chk1("mid_rst_cfg_err", bus.cfg_err, 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    st_act[0] = 57; st_wgt[0] = 8'hB6;
    run(0, 1, 0, 0);
    chk("t5_model", exp_res, ACC_W'(-4218));

    st_act[0] = 127; st_wgt[0] = 8'h80;
    st_act[1] = -128; st_wgt[1] = 8'h7F;
    st_act[2] = -1; st_wgt[2] = 8'hFF;
    st_act[3] = 55; st_wgt[3] = 8'h3C;
    run(0, 4, 1, 0);

    for (int i = 0; i < 200; i++) begin st_act[i] = 127; st_wgt[i] = 8'h55; end
    run(2, 200, 0, 0);
`ifdef MAC_SAT_EN
    lit = {4{14'h1FFF}};
    msat = 1'b1;
`else
    lit = {4{14'h2338}};
    msat = 1'b0;
`endif
    chk("t7_model", exp_res, lit);
    chk1("t7_model_sat", exp_sat, msat);
    chk("t7_result", got, lit);

    @(negedge clk);
    bus.start = 1'b1; bus.cfg_prec = 2'b00; bus.cfg_len = 0;
    @(negedge clk);
    bus.start = 1'b0;
    chk1("len0_cfg_err", bus.cfg_err, 1'b1);
    @(negedge clk);
    chk1("len0_idle", bus.in_ready, 1'b0);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("rst2_cfg_err", bus.cfg_err, 1'b0);
    st_act[0] = -3; st_wgt[0] = 8'h05;
    run(3, 1, 0, 0);
    chk("rsv_result", got, 56'hFFFFFFFFFFFFF1);
    chk1("rsv_cfg_err", bus.cfg_err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
